// File: rtl/btb_flush_ctrl_if.sv
// ---------------------------------------------------------------------------
// btb_flush_ctrl_if
//
// Purpose:
//   Bundles the signals between the pipeline/BTB side and the BTB flush
//   sequencer. The single BTB write port is carried here together with the
//   pipeline update request that competes for it.
//
// Optional feature macro: BTB_FLUSH_STATS_EN
//   When defined, the interface also carries the sweep/drop statistics
//   counters flush_cnt and drop_cnt.
//
// Signals (direction as seen by the controller, modport "slave"):
//   en_cfg      in   software enable for BTB prediction
//   flush_req   in   single-cycle request to invalidate the whole table
//   upd_we      in   pipeline update write request
//   upd_idx     in   pipeline update index            [IDX_W]
//   upd_data    in   pipeline update line contents    [ENTRY_W]
//   mem_we      out  BTB write enable
//   mem_idx     out  BTB write index                  [IDX_W]
//   mem_data    out  BTB write data                   [ENTRY_W]
//   btb_en      out  lookup enable to the BTB (hit qualifier)
//   flush_busy  out  sweep in progress
//   flush_done  out  one-cycle pulse when a sweep completes
//   upd_dropped out  one-cycle pulse: upd_we discarded this cycle
//   flush_cnt   out  completed sweeps, saturating     [8]  (stats only)
//   drop_cnt    out  dropped updates, saturating      [16] (stats only)
//
// Modports:
//   master - pipeline / software side that issues requests
//   slave  - the flush controller
// ---------------------------------------------------------------------------
interface btb_flush_ctrl_if #(
  parameter int IDX_W   = 9,
  parameter int ENTRY_W = 25
);

  logic               en_cfg;
  logic               flush_req;
  logic               upd_we;
  logic [IDX_W-1:0]   upd_idx;
  logic [ENTRY_W-1:0] upd_data;

  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [ENTRY_W-1:0] mem_data;
  logic               btb_en;
  logic               flush_busy;
  logic               flush_done;
  logic               upd_dropped;

`ifdef BTB_FLUSH_STATS_EN
  logic [7:0]         flush_cnt;
  logic [15:0]        drop_cnt;

  modport master (
    output en_cfg, flush_req, upd_we, upd_idx, upd_data,
    input  mem_we, mem_idx, mem_data, btb_en,
    input  flush_busy, flush_done, upd_dropped,
    input  flush_cnt, drop_cnt
  );

  modport slave (
    input  en_cfg, flush_req, upd_we, upd_idx, upd_data,
    output mem_we, mem_idx, mem_data, btb_en,
    output flush_busy, flush_done, upd_dropped,
    output flush_cnt, drop_cnt
  );
`else
  modport master (
    output en_cfg, flush_req, upd_we, upd_idx, upd_data,
    input  mem_we, mem_idx, mem_data, btb_en,
    input  flush_busy, flush_done, upd_dropped
  );

  modport slave (
    input  en_cfg, flush_req, upd_we, upd_idx, upd_data,
    output mem_we, mem_idx, mem_data, btb_en,
    output flush_busy, flush_done, upd_dropped
  );
`endif

endinterface

// File: rtl/btb_flush_ctrl.sv
// ---------------------------------------------------------------------------
// btb_flush_ctrl
//
// Purpose:
//   Sequencer and write-port arbiter for the branch target buffer. After
//   reset, and whenever a flush is requested, it walks every BTB line and
//   writes an all-zero line (valid bit cleared), one line per clock. While
//   the sweep runs it owns the single BTB write port and holds lookups off
//   (btb_en low) so stale lines can neither hit nor trigger strong/evict
//   updates. Outside a sweep the EX-stage update write passes straight
//   through to the write port with no added latency.
//
// Optional feature macro: BTB_FLUSH_STATS_EN
//   When defined, flush_cnt (completed sweeps, saturating at 255) and
//   drop_cnt (dropped updates, saturating at 16'hFFFF) are maintained and
//   driven onto the interface. When undefined they do not exist.
//
// Ports:
//   clk    in  system clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of btb_flush_ctrl_if (requests, BTB write port,
//          lookup enable and status pulses)
//
// Parameters:
//   ENTRIES  number of BTB lines (power of two)
//   IDX_W    log2(ENTRIES)
//   ENTRY_W  line width: tag[24:18], strong[17], valid[16], target[15:0]
// ---------------------------------------------------------------------------
module btb_flush_ctrl #(
  parameter int ENTRIES = 512,
  parameter int IDX_W   = 9,
  parameter int ENTRY_W = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  btb_flush_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] sweepIdx_q;
  logic             armed_q;
  logic             busy_q;
  logic             done_q;
  logic             passThru_q;

  logic             sweepAct;
  logic             updDropped;

  // The sweep only drives the port once the first clock edge after reset
  // release has been seen. During reset and in that first cycle the port
  // stays quiet, so reset values hold on the write port while rst_n is low
  // and the sweep then writes lines 0..ENTRIES-1 on consecutive cycles.
  assign sweepAct   = (state_q == SWEEP) && armed_q;

  // The sweep always wins the write port; an update that arrives while the
  // sweep is writing is discarded and reported.
  assign updDropped = sweepAct & bus.upd_we;

  // Single FSM block. passThru_q is high in IDLE and DONE: the states in
  // which lookups may be enabled and updates reach the BTB. A flush request
  // (re)starts the sweep at line 0 from any armed state, so a restarted
  // sweep always runs a full ENTRIES cycles and only then pulses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SWEEP;
      sweepIdx_q <= '0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      passThru_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        SWEEP: begin
          if (!armed_q || bus.flush_req) begin
            sweepIdx_q <= '0;
          end else if (sweepIdx_q == LAST_IDX) begin
            state_q    <= DONE;
            sweepIdx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            passThru_q <= 1'b1;
          end else begin
            sweepIdx_q <= sweepIdx_q + IDX_W'(1);
          end
        end
        IDLE, DONE: begin
          if (bus.flush_req) begin
            state_q    <= SWEEP;
            sweepIdx_q <= '0;
            busy_q     <= 1'b1;
            passThru_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= SWEEP;
          sweepIdx_q <= '0;
          busy_q     <= 1'b1;
          passThru_q <= 1'b0;
        end
      endcase
    end
  end

  // Write-port mux. Outside a sweep the update request is forwarded
  // combinationally; during reset and the post-reset cycle everything is 0.
  assign bus.mem_we   = sweepAct | (passThru_q & bus.upd_we);
  assign bus.mem_idx  = sweepAct   ? sweepIdx_q   :
                        passThru_q ? bus.upd_idx  : '0;
  assign bus.mem_data = passThru_q ? bus.upd_data : '0;

  assign bus.btb_en      = passThru_q & bus.en_cfg;
  assign bus.flush_busy  = busy_q;
  assign bus.flush_done  = done_q;
  assign bus.upd_dropped = updDropped;

`ifdef BTB_FLUSH_STATS_EN
  logic [7:0]  flushCnt_q;
  logic [7:0]  flushCnt_d;
  logic [15:0] dropCnt_q;
  logic [15:0] dropCnt_d;

  // Saturating event counters; each reflects its pulse one cycle later.
  always_comb begin
    flushCnt_d = flushCnt_q;
    dropCnt_d  = dropCnt_q;
    if (done_q && (flushCnt_q != 8'hFF)) begin
      flushCnt_d = flushCnt_q + 8'd1;
    end
    if (updDropped && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_d = dropCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushCnt_q <= '0;
      dropCnt_q  <= '0;
    end else begin
      flushCnt_q <= flushCnt_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  assign bus.flush_cnt = flushCnt_q;
  assign bus.drop_cnt  = dropCnt_q;
`endif

endmodule

// File: tb/tb_btb_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btb_flush_ctrl
//
// Self-checking bench for btb_flush_ctrl. A behavioural model tracks the
// sweep as "which line is being cleared this cycle" (or none), plus a flag
// for the quiet cycle after reset release and a flag for the completion
// pulse; every cycle all outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_btb_flush_ctrl;

  localparam int ENTRIES = 512;
  localparam int IDX_W   = 9;
  localparam int ENTRY_W = 25;

  logic clk;
  logic rst_n;

  btb_flush_ctrl_if #(.IDX_W(IDX_W), .ENTRY_W(ENTRY_W)) bus ();

  btb_flush_ctrl #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .ENTRY_W (ENTRY_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount;
  int checkCount;

  // Reference model. mSweepPos is the line being cleared this cycle, or -1
  // when no sweep is running. mRecovering marks the quiet first cycle after
  // reset release. mDoneNow marks the cycle that carries flush_done.
  int mSweepPos;
  bit mRecovering;
  bit mDoneNow;
  int mFlushCnt;
  int mDropCnt;
  bit expDropNow;
  bit curEn;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic modelReset();
    mSweepPos   = 0;
    mRecovering = 1'b1;
    mDoneNow    = 1'b0;
    mFlushCnt   = 0;
    mDropCnt    = 0;
  endtask

  // Compare every output against what the model expects right now.
  task automatic compareAll();
    bit inReset;
    bit sweeping;
    bit passThru;
    logic [31:0] expIdx;
    logic [31:0] expData;
    inReset  = !rst_n;
    sweeping = !inReset && !mRecovering && (mSweepPos >= 0);
    passThru = !inReset && !mRecovering && (mSweepPos < 0);
    expIdx   = sweeping ? 32'(mSweepPos) :
               passThru ? 32'(bus.upd_idx) : 32'd0;
    expData  = passThru ? 32'(bus.upd_data) : 32'd0;
    expDropNow = sweeping && bus.upd_we;
    checkOutput("mem_we",      32'(bus.mem_we),
                32'(sweeping || (passThru && bus.upd_we)));
    checkOutput("mem_idx",     32'(bus.mem_idx), expIdx);
    checkOutput("mem_data",    32'(bus.mem_data), expData);
    checkOutput("btb_en",      32'(bus.btb_en), 32'(passThru && bus.en_cfg));
    checkOutput("flush_busy",  32'(bus.flush_busy), 32'(!passThru));
    checkOutput("flush_done",  32'(bus.flush_done), 32'(!inReset && mDoneNow));
    checkOutput("upd_dropped", 32'(bus.upd_dropped), 32'(expDropNow));
`ifdef BTB_FLUSH_STATS_EN
    checkOutput("flush_cnt",   32'(bus.flush_cnt), inReset ? 32'd0 : 32'(mFlushCnt));
    checkOutput("drop_cnt",    32'(bus.drop_cnt),  inReset ? 32'd0 : 32'(mDropCnt));
`endif
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic modelStep();
    if (!rst_n) begin
      modelReset();
    end else begin
      if (expDropNow && mDropCnt < 65535) mDropCnt++;
      if (mDoneNow && mFlushCnt < 255) mFlushCnt++;
      mDoneNow = 1'b0;
      if (mRecovering) begin
        mRecovering = 1'b0;
        mSweepPos   = 0;
      end else if (mSweepPos >= 0) begin
        if (bus.flush_req) begin
          mSweepPos = 0;
        end else if (mSweepPos == ENTRIES - 1) begin
          mSweepPos = -1;
          mDoneNow  = 1'b1;
        end else begin
          mSweepPos++;
        end
      end else if (bus.flush_req) begin
        mSweepPos = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the
  // falling edge, step the model, then move to just after the next edge.
  task automatic applyStimulus(input bit flush, input bit upd,
                               input logic [IDX_W-1:0] uIdx,
                               input logic [ENTRY_W-1:0] uData);
    bus.en_cfg    = curEn;
    bus.flush_req = flush;
    bus.upd_we    = upd;
    bus.upd_idx   = uIdx;
    bus.upd_data  = uData;
    @(negedge clk);
    compareAll();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, IDX_W'($urandom), ENTRY_W'($urandom));
  endtask

  task automatic runUntilDone(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bus.flush_done) break;
      idleCycle();
    end
    checkOutput("sweepEnd", 32'(bus.flush_done), 32'd1);
  endtask

  task automatic runUntilIdx(input int target);
    for (int i = 0; i < ENTRIES + 8; i++) begin
      if (!mRecovering && mSweepPos == target) break;
      idleCycle();
    end
    checkOutput("idxReach", 32'(bus.mem_idx), 32'(target));
  endtask

  // Asynchronous reset pulse in the middle of a cycle, held for two edges.
  task automatic resetPulse();
    bus.flush_req = 1'b0;
    bus.upd_we    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compareAll();
    modelReset();
    idleCycle();
    idleCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    passCount     = 0;
    checkCount    = 0;
    curEn         = 1'b1;
    expDropNow    = 1'b0;
    rst_n         = 1'b0;
    bus.en_cfg    = 1'b1;
    bus.flush_req = 1'b0;
    bus.upd_we    = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_data  = '0;
    modelReset();

    // Reset values, then the power-on sweep.
    @(posedge clk);
    #1;
    idleCycle();
    idleCycle();
    rst_n = 1'b1;
    $display("[TB] power-on sweep");
    runUntilDone(ENTRIES + 8);

    // DONE cycle, then a same-cycle update pass-through in IDLE.
    idleCycle();
    applyStimulus(1'b0, 1'b1, 9'h0A3, 25'h0012345);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'($urandom), IDX_W'($urandom), ENTRY_W'($urandom));
    end

    // Flush from IDLE with a concurrent update, dropped update at line 100,
    // restart at line 300, then a full sweep to completion.
    $display("[TB] flush, drop and restart");
    applyStimulus(1'b1, 1'b1, 9'h155, 25'h1ABCDEF);
    runUntilIdx(100);
    applyStimulus(1'b0, 1'b1, 9'h033, 25'h0F0F0F0);
    runUntilIdx(300);
    applyStimulus(1'b1, 1'b0, '0, '0);
    runUntilDone(ENTRIES + 8);

    // Flush requested in the DONE cycle together with an update.
    applyStimulus(1'b1, 1'b1, 9'h1FF, 25'h1FFFFFF);
    runUntilIdx(250);
    resetPulse();
    runUntilDone(ENTRIES + 8);

    // Randomised traffic with rare flushes, enable changes and resets.
    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) curEn = ~curEn;
      if ($urandom_range(0, 1499) == 0) begin
        resetPulse();
      end else begin
        applyStimulus($urandom_range(0, 299) == 0, 1'($urandom),
                      IDX_W'($urandom), ENTRY_W'($urandom));
      end
    end

    // Statistics scenario: lookups disabled, power-on sweep with two dropped
    // updates, then three requested sweeps.
    $display("[TB] statistics scenario");
    curEn = 1'b0;
    resetPulse();
    runUntilIdx(10);
    applyStimulus(1'b0, 1'b1, 9'h00A, 25'h0000001);
    runUntilIdx(20);
    applyStimulus(1'b0, 1'b1, 9'h014, 25'h0000002);
    runUntilDone(ENTRIES + 8);
    for (int s = 0; s < 3; s++) begin
      idleCycle();
      applyStimulus(1'b1, 1'b0, '0, '0);
      runUntilDone(ENTRIES + 8);
    end
    idleCycle();
    idleCycle();
`ifdef BTB_FLUSH_STATS_EN
    checkOutput("flushTotal", 32'(bus.flush_cnt), 32'd4);
    checkOutput("dropTotal",  32'(bus.drop_cnt),  32'd2);
`endif
    checkOutput("btbEnOff", 32'(bus.btb_en), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
